alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Registered, handshaked RV32 decode stage; successor to the combinational ALU-control decoder.
- Covers R-type, I-type ALU, LOAD, STORE and BRANCH.
- Emits a parametrised-width ALU control code plus datapath control bits.
- Sits between fetch and execute; optional M-extension ops hold the stage for a programmable multi-cycle latency.

Parameters:
- ALUCTRL_W, 5, width of alu_ctrl (must be ≥5).
- MUL_CYCLES, 1, total accept-to-out_valid latency for MUL/MULH/MULHSU/MULHU (≥1).
- DIV_CYCLES, 4, total accept-to-out_valid latency for DIV/DIVU/REM/REMU (≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops the held/pending result.
- instr  in  32  instruction word.
- in_valid  in  1  instr valid.
- in_ready  out  1  stage can accept.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  execute accepts the result.
- alu_ctrl  out  ALUCTRL_W  ALU operation code.
- alu_src_imm  out  1  operand B is the immediate.
- reg_write  out  1  writes rd.
- mem_read  out  1  load.
- mem_write  out  1  store.
- branch  out  1  conditional branch.
- illegal  out  1  unsupported encoding.
- busy  out  1  multi-cycle wait in progress.

Behaviour:
- Encodings:
  - Base: ADD 0, SUB 1, AND 2, OR 3, SLL 4, SRL 5, SRA 6, XOR 7, SLT 8, SLTU 9.
  - M-extension: 16+funct3 (MUL 16 … REMU 23).
  - Upper bits are zero-extended when ALUCTRL_W > 5.
- R-type (0110011), funct7 = 0x00: f3 0→ADD, 1→SLL, 2→SLT, 3→SLTU, 4→XOR, 5→SRL, 6→OR, 7→AND.
- R-type, funct7 = 0x20: f3 0→SUB, f3 5→SRA; any other f3 is illegal. Any other funct7 is illegal (see Optional Feature).
- I-ALU (0010011):
  - Same f3 map, except f3 0 is always ADD.
  - f3 5 with instr[30]=1 → SRA; f3 1/5 with instr[31:25] outside {0x00, 0x20 (f3 5 only)} is illegal.
  - alu_src_imm=1, reg_write=1.
- LOAD (0000011): ADD, alu_src_imm, mem_read, reg_write.
- STORE (0100011): ADD, alu_src_imm, mem_write.
- BRANCH (1100011): branch=1; f3 0/1→SUB, 4/5→SLT, 6/7→SLTU; f3 2/3 illegal.
- Illegal result: alu_ctrl=ADD, illegal=1, all other control bits 0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- FSM states:
  - IDLE: on accept of a single-cycle op, register the decode; out_valid=1 next cycle (latency 1).
  - IDLE: on accept of an M-op with latency L>1, go to WAIT, counter=L-1, busy=1, decode held internally.
  - WAIT: counter decrements each cycle; on reaching 1, go to IDLE and set out_valid next cycle, so out_valid rises exactly L cycles after accept.
- Output hold: out_valid, once set, holds with stable outputs until out_ready.
- Simultaneous out_valid&&out_ready&&in_valid accepts the new instr; throughput is 1/cycle.
- flush: out_valid←0, busy←0, state←IDLE; same-cycle in_valid is ignored (in_ready forced 0 during flush).
- Reset (async): state IDLE, counter 0, out_valid 0, busy 0, alu_ctrl 0, illegal 0, all control bits 0; an in-flight multi-cycle op is discarded.

Optional Feature:
- Macro RV32M_EN.
- Defined: R-type funct7=0x01 decodes M-ops using MUL_CYCLES/DIV_CYCLES and the WAIT state.
- Undefined: funct7=0x01 is illegal, the WAIT state and counter are not built, and busy is tied 0.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALU code constants: ALU_ADD … ALU_REMU;
  - FSM state typedef.
- One sub-module, alu_ctrl_decode: purely combinational instr→control bundle, used by the registered/FSM wrapper.

Test Plan:
- 0x003100B3 (add), then 0x403100B3 (sub), in consecutive cycles with out_ready=1 → out_valid on cycles +1 and +2, alu_ctrl 0 then 1, reg_write=1, in_ready stays 1.
- 0x40315093 (srai) → alu_ctrl=6, alu_src_imm=1; 0x00012083 (lw) → alu_ctrl=0, mem_read=1, reg_write=1.
- out_ready=0 for 3 cycles after add → outputs stable, in_ready=0; out_ready=1 with a new in_valid → accepted that cycle.
- RV32M_EN, DIV_CYCLES=4, 0x023140B3 (div) → busy=1 for 3 cycles, out_valid 4 cycles after accept, alu_ctrl=20. Without the macro → illegal=1 after 1 cycle.
- rst or flush asserted during WAIT → out_valid=0, busy=0, in_ready=1 the next cycle; no stale div result ever appears.
- Opcode 0x7F, or R-type funct7=0x20 with f3=7 → illegal=1, alu_ctrl=0, all control bits 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared RV32 decode constants, ALU codes and stage types
//
// Purpose : opcode/funct7 constants, ALU control codes, FSM state type and the
//           internal control bundle shared by alu_ctrl_decode and alu_decode_stage.
// Ports   : none (package).
// Config  : RV32M_EN selects whether M-extension ops are decoded (users of this package).

package rv_ctrl_pkg;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct7 classes
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  // ALU control codes (5 significant bits; wider outputs are zero-extended)
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_SLL    = 5'd4;
  localparam logic [4:0] ALU_SRL    = 5'd5;
  localparam logic [4:0] ALU_SRA    = 5'd6;
  localparam logic [4:0] ALU_XOR    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Decoded control bundle as carried through the stage registers
  typedef struct packed {
    logic [4:0] alu;
    logic       alu_src_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  // funct3 -> ALU op for the non-alternate R/I arithmetic group
  function automatic logic [4:0] base_alu(input logic [2:0] funct3);
    logic [4:0] code;
    case (funct3)
      3'd0:    code = ALU_ADD;
      3'd1:    code = ALU_SLL;
      3'd2:    code = ALU_SLT;
      3'd3:    code = ALU_SLTU;
      3'd4:    code = ALU_XOR;
      3'd5:    code = ALU_SRL;
      3'd6:    code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // funct3 -> ALU op for the M-extension group
  function automatic logic [4:0] m_alu(input logic [2:0] funct3);
    logic [4:0] code;
    case (funct3)
      3'd0:    code = ALU_MUL;
      3'd1:    code = ALU_MULH;
      3'd2:    code = ALU_MULHSU;
      3'd3:    code = ALU_MULHU;
      3'd4:    code = ALU_DIV;
      3'd5:    code = ALU_DIVU;
      3'd6:    code = ALU_REM;
      default: code = ALU_REMU;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational RV32 instr to ALU/datapath control decoder
//
// Purpose : decodes R-type, I-type ALU, LOAD, STORE and BRANCH into a 5-bit ALU
//           code plus datapath control bits. Unsupported encodings produce
//           ALU_ADD with illegal=1 and every other control bit cleared.
// Ports   : instr (in, 32)      instruction word
//           alu_ctrl (out, 5)   ALU operation code
//           alu_src_imm, reg_write, mem_read, mem_write, branch, illegal (out, 1)
//           is_mop, is_div (out, 1, RV32M_EN only) multi-cycle op class
// Config  : RV32M_EN - decode funct7=0x01 R-type as M-extension ops.

module alu_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  alu_ctrl,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        illegal
`ifdef RV32M_EN
  ,
  output logic        is_mop,
  output logic        is_div
`endif
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register/immediate fields do not influence control
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    alu_ctrl    = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    illegal     = 1'b0;
    bad         = 1'b0;
`ifdef RV32M_EN
    is_mop      = 1'b0;
    is_div      = 1'b0;
`endif
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          alu_ctrl = base_alu(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
          alu_ctrl = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
          alu_ctrl = ALU_SRA;
`ifdef RV32M_EN
        end else if (funct7 == F7_MULDIV) begin
          alu_ctrl = m_alu(funct3);
          is_mop   = 1'b1;
          is_div   = funct3[2];  // DIV/DIVU/REM/REMU occupy funct3 4..7
`endif
        end else begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        // funct3 0 is ADDI regardless of immediate bits; shifts check funct7
        alu_src_imm = 1'b1;
        reg_write   = 1'b1;
        alu_ctrl    = base_alu(funct3);
        if (funct3 == 3'd1 && funct7 != F7_BASE) begin
          bad = 1'b1;
        end
        if (funct3 == 3'd5) begin
          if (funct7 == F7_ALT) begin
            alu_ctrl = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            bad = 1'b1;
          end
        end
      end
      OP_LOAD: begin
        alu_src_imm = 1'b1;
        mem_read    = 1'b1;
        reg_write   = 1'b1;
      end
      OP_STORE: begin
        alu_src_imm = 1'b1;
        mem_write   = 1'b1;
      end
      OP_BRANCH: begin
        branch = 1'b1;
        case (funct3)
          3'd0, 3'd1: alu_ctrl = ALU_SUB;
          3'd4, 3'd5: alu_ctrl = ALU_SLT;
          3'd6, 3'd7: alu_ctrl = ALU_SLTU;
          default:    bad      = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      alu_ctrl    = ALU_ADD;
      alu_src_imm = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      branch      = 1'b0;
      illegal     = 1'b1;
`ifdef RV32M_EN
      is_mop      = 1'b0;
      is_div      = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - registered, handshaked RV32 decode stage
//
// Purpose : registers the alu_ctrl_decode result between fetch and execute with a
//           valid/ready handshake (1 result/cycle). M-extension ops may hold the
//           stage in a WAIT state for MUL_CYCLES/DIV_CYCLES accept-to-valid latency.
// Ports   : clk, rst (async, active high), flush (sync, drops held/pending result)
//           instr[31:0], in_valid -> in_ready          upstream handshake
//           out_valid -> out_ready                       downstream handshake
//           alu_ctrl[ALUCTRL_W-1:0], alu_src_imm, reg_write, mem_read, mem_write,
//           branch, illegal                              registered decode
//           busy                                         multi-cycle wait in progress
// Config  : RV32M_EN - build M-op decode, WAIT state and latency counter;
//           without it busy is tied low and funct7=0x01 is illegal.

module alu_decode_stage #(
  parameter int ALUCTRL_W  = 5,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [31:0]          instr,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 alu_src_imm,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 branch,
  output logic                 illegal,
  output logic                 busy
);

  import rv_ctrl_pkg::*;

  if (ALUCTRL_W < 5) begin : g_bad_alu_w
    $error("alu_decode_stage: ALUCTRL_W must be at least 5");
  end
  if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_lat
    $error("alu_decode_stage: MUL_CYCLES and DIV_CYCLES must be at least 1");
  end

  logic [4:0] dec_alu;
  logic       dec_src_imm, dec_reg_write, dec_mem_read, dec_mem_write;
  logic       dec_branch, dec_illegal;
  ctrl_t      dec;

  ctrl_t      out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       stage_idle;
  logic       in_ready_c;
  logic       accept;
  logic [ALUCTRL_W-1:0] alu_ctrl_ext;

`ifdef RV32M_EN
  localparam int LAT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  logic             dec_is_mop, dec_is_div;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] op_lat;
  logic             busy_q, busy_d;
  ctrl_t            pend_q, pend_d;
`endif

  alu_ctrl_decode u_alu_ctrl_decode (
    .instr       (instr),
    .alu_ctrl    (dec_alu),
    .alu_src_imm (dec_src_imm),
    .reg_write   (dec_reg_write),
    .mem_read    (dec_mem_read),
    .mem_write   (dec_mem_write),
    .branch      (dec_branch),
    .illegal     (dec_illegal)
`ifdef RV32M_EN
    ,
    .is_mop      (dec_is_mop),
    .is_div      (dec_is_div)
`endif
  );

  always_comb begin
    dec             = '0;
    dec.alu         = dec_alu;
    dec.alu_src_imm = dec_src_imm;
    dec.reg_write   = dec_reg_write;
    dec.mem_read    = dec_mem_read;
    dec.mem_write   = dec_mem_write;
    dec.branch      = dec_branch;
    dec.illegal     = dec_illegal;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
`ifdef RV32M_EN
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    pend_d      = pend_q;
    op_lat      = dec_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    stage_idle  = (state_q == ST_IDLE);
`else
    stage_idle  = 1'b1;
`endif
    // Flush blocks acceptance so a same-cycle instruction is never captured
    in_ready_c = stage_idle && (!out_valid_q || out_ready) && !flush;
    accept     = in_valid && in_ready_c;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      out_valid_d = 1'b0;
`ifdef RV32M_EN
      state_d     = ST_IDLE;
      cnt_d       = '0;
      busy_d      = 1'b0;
`endif
    end
`ifdef RV32M_EN
    else if (state_q == ST_WAIT) begin
      // Release on the cycle the counter reads 1 so out_valid lands exactly L after accept
      if (cnt_q == CNT_W'(1)) begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        busy_d      = 1'b0;
        out_valid_d = 1'b1;
        out_d       = pend_q;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    else if (accept && dec_is_mop && (op_lat > CNT_W'(1))) begin
      state_d = ST_WAIT;
      cnt_d   = op_lat - CNT_W'(1);
      busy_d  = 1'b1;
      pend_d  = dec;
    end
`endif
    else if (accept) begin
      out_valid_d = 1'b1;
      out_d       = dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
`ifdef RV32M_EN
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      pend_q      <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
`ifdef RV32M_EN
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
`endif
    end
  end

  always_comb begin
    alu_ctrl_ext      = '0;
    alu_ctrl_ext[4:0] = out_q.alu;
  end

  assign in_ready    = in_ready_c;
  assign out_valid   = out_valid_q;
  assign alu_ctrl    = alu_ctrl_ext;
  assign alu_src_imm = out_q.alu_src_imm;
  assign reg_write   = out_q.reg_write;
  assign mem_read    = out_q.mem_read;
  assign mem_write   = out_q.mem_write;
  assign branch      = out_q.branch;
  assign illegal     = out_q.illegal;
`ifdef RV32M_EN
  assign busy        = busy_q;
`else
  assign busy        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - self-checking bench for alu_decode_stage

module tb_alu_decode_stage;

  localparam int W    = 8;
  localparam int MUL_L = 1;
  localparam int DIV_L = 4;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_SRAI = 32'h40315093;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_DIV  = 32'h023140B3;
  localparam logic [31:0] I_BAD1 = 32'h0000007F;
  localparam logic [31:0] I_BAD2 = 32'h400070B3;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [31:0]  instr;
  logic         in_ready, out_valid;
  logic [W-1:0] alu_ctrl;
  logic         alu_src_imm, reg_write, mem_read, mem_write, branch, illegal, busy;
  logic [4:0]   bits;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign bits = {alu_src_imm, reg_write, mem_read, mem_write, branch};

  alu_decode_stage #(.ALUCTRL_W(W), .MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
    .clk(clk), .rst(rst), .flush(flush), .instr(instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .illegal(illegal), .busy(busy)
  );

  // Expected decode: {alu code, {src_imm, reg_write, mem_read, mem_write, branch}, illegal}
  typedef struct packed {
    logic [W-1:0] alu;
    logic [4:0]   bits;
    logic         ill;
  } exp_t;

  function automatic exp_t ref_dec(input logic [31:0] ins);
    int   tbl[8] = '{0, 4, 8, 9, 7, 5, 3, 2};  // ADD SLL SLT SLTU XOR SRL OR AND
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    int   code = 0;
    logic ok = 1'b1;
    logic [4:0] b = 5'b0;
    exp_t e;
    if (op == 7'h33) begin
      b = 5'b01000;
      if (f7 == 7'h00) code = tbl[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) code = 6;
      else if (M_EN && f7 == 7'h01) code = 16 + int'(f3);
      else ok = 1'b0;
    end else if (op == 7'h13) begin
      b = 5'b11000;
      code = tbl[f3];
      if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
      if (f3 == 3'd5) begin
        if (f7 == 7'h20) code = 6;
        else if (f7 != 7'h00) ok = 1'b0;
      end
    end else if (op == 7'h03) begin
      b = 5'b11100;
    end else if (op == 7'h23) begin
      b = 5'b10010;
    end else if (op == 7'h63) begin
      b = 5'b00001;
      if (f3 == 3'd0 || f3 == 3'd1) code = 1;
      else if (f3 == 3'd4 || f3 == 3'd5) code = 8;
      else if (f3 == 3'd6 || f3 == 3'd7) code = 9;
      else ok = 1'b0;
    end else begin
      ok = 1'b0;
    end
    if (ok) begin
      e.alu = W'(code); e.bits = b; e.ill = 1'b0;
    end else begin
      e.alu = '0; e.bits = 5'b0; e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic int ref_lat(input logic [31:0] ins);
    if (M_EN && ins[6:0] == 7'h33 && ins[31:25] == 7'h01 && !ref_dec(ins).ill)
      return ins[14] ? DIV_L : MUL_L;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else passed++;
    checks++; if (alu_ctrl !== '0) $display("FAIL reset_alu_ctrl got=%0d exp=0", alu_ctrl); else passed++;
    checks++; if (bits !== 5'b0 || illegal !== 1'b0) $display("FAIL reset_ctrl got=%b/%0b exp=00000/0", bits, illegal); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; instr = I_ADD; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0 got=%0b exp=1", in_ready); else passed++;
    tick();
    instr = I_SUB;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 8'd0 || reg_write !== 1'b1) $display("FAIL b2b_add got=v%0b a%0d rw%0b exp=v1 a0 rw1", out_valid, alu_ctrl, reg_write); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got=%0b exp=1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 8'd1 || reg_write !== 1'b1) $display("FAIL b2b_sub got=v%0b a%0d rw%0b exp=v1 a1 rw1", out_valid, alu_ctrl, reg_write); else passed++;
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%0b exp=0", out_valid); else passed++;
    tick();
  endtask

  task automatic test_imm_load();
    in_valid = 1'b1; instr = I_SRAI; out_ready = 1'b1;
    tick();
    instr = I_LW;
    @(negedge clk);
    checks++; if (alu_ctrl !== 8'd6 || bits !== 5'b11000) $display("FAIL srai got=a%0d b%b exp=a6 b11000", alu_ctrl, bits); else passed++;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (alu_ctrl !== 8'd0 || bits !== 5'b11100) $display("FAIL lw got=a%0d b%b exp=a0 b11100", alu_ctrl, bits); else passed++;
    tick();
  endtask

  task automatic test_stall();
    in_valid = 1'b1; instr = I_ADD; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; instr = I_SUB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || alu_ctrl !== 8'd0 || in_ready !== 1'b0) $display("FAIL stall_hold%0d got=v%0b a%0d r%0b exp=v1 a0 r0", i, out_valid, alu_ctrl, in_ready); else passed++;
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL stall_release got=%0b exp=1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 8'd1) $display("FAIL stall_next got=v%0b a%0d exp=v1 a1", out_valid, alu_ctrl); else passed++;
    tick();
  endtask

  task automatic test_div();
    in_valid = 1'b1; instr = I_DIV; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    if (M_EN) begin
      for (int i = 1; i < DIV_L; i++) begin
        @(negedge clk);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL div_wait%0d got=b%0b v%0b r%0b exp=b1 v0 r0", i, busy, out_valid, in_ready); else passed++;
        tick();
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || alu_ctrl !== 8'd20 || busy !== 1'b0) $display("FAIL div_done got=v%0b a%0d b%0b exp=v1 a20 b0", out_valid, alu_ctrl, busy); else passed++;
    end else begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_ctrl !== 8'd0) $display("FAIL div_illegal got=v%0b i%0b a%0d exp=v1 i1 a0", out_valid, illegal, alu_ctrl); else passed++;
    end
    tick();
  endtask

  task automatic test_flush_reset();
    in_valid = 1'b1; instr = I_DIV; out_ready = 1'b0;
    tick();
    instr = I_ADD; flush = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%0b exp=0", in_ready); else passed++;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_after got=v%0b b%0b r%0b exp=v0 b0 r1", out_valid, busy, in_ready); else passed++;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_stale%0d got=%0b exp=0", i, out_valid); else passed++;
    end
    tick();
    in_valid = 1'b1; instr = I_DIV;
    tick();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_after got=v%0b b%0b r%0b exp=v0 b0 r1", out_valid, busy, in_ready); else passed++;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_stale%0d got=%0b exp=0", i, out_valid); else passed++;
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = I_BAD1; bad[1] = I_BAD2;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; instr = bad[i]; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_ctrl !== '0 || bits !== 5'b0) $display("FAIL illegal%0d got=v%0b i%0b a%0d b%b exp=v1 i1 a0 b00000", i, out_valid, illegal, alu_ctrl, bits); else passed++;
      tick();
    end
  endtask

  // Timeline model: an accepted op becomes visible L cycles later and stays until taken
  task automatic test_random();
    bit   m_has = 1'b0;
    int   m_rdy = 0;
    exp_t m_res = '0;
    bit   e_ov, e_busy, e_ir;
    logic [31:0] r;
    logic [6:0]  op, f7;
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      case ($urandom_range(0, 5))
        0: op = 7'h33;
        1: op = 7'h13;
        2: op = 7'h03;
        3: op = 7'h23;
        4: op = 7'h63;
        default: op = 7'($urandom());
      endcase
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom());
      endcase
      r[6:0] = op; r[31:25] = f7;
      instr     = r;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      e_ov   = m_has && (c >= m_rdy);
      e_busy = m_has && (c < m_rdy);
      e_ir   = !flush && !e_busy && (!e_ov || out_ready);
      checks++; if (out_valid !== e_ov || in_ready !== e_ir || busy !== e_busy) $display("FAIL rand_hs c%0d got=v%0b r%0b b%0b exp=v%0b r%0b b%0b", c, out_valid, in_ready, busy, e_ov, e_ir, e_busy); else passed++;
      if (e_ov) begin
        checks++; if (alu_ctrl !== m_res.alu || bits !== m_res.bits || illegal !== m_res.ill) $display("FAIL rand_data c%0d got=a%0d b%b i%0b exp=a%0d b%b i%0b", c, alu_ctrl, bits, illegal, m_res.alu, m_res.bits, m_res.ill); else passed++;
      end
      if (flush) begin
        m_has = 1'b0;
      end else begin
        if (e_ov && out_ready) m_has = 1'b0;
        if (in_valid && e_ir) begin
          m_has = 1'b1;
          m_res = ref_dec(instr);
          m_rdy = c + ref_lat(instr);
        end
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_imm_load();
    test_stall();
    test_div();
    test_flush_reset();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
